// File: rtl/kpg_pkg.sv
// Shared kill/propagate/generate definitions used by the adder and subtractor carry networks.
package kpg_pkg;

  typedef enum logic [1:0] {
    KPG_K = 2'b00,
    KPG_P = 2'b01,
    KPG_G = 2'b10
  } kpg_t;

  // x is the more-significant span; the illegal code 2'b11 resolves as kill.
  function automatic kpg_t kpg_combine(input kpg_t x, input kpg_t y);
    case (x)
      KPG_P:   return y;
      KPG_G:   return KPG_G;
      default: return KPG_K;
    endcase
  endfunction

  function automatic kpg_t kpg_encode(input logic a_bit, input logic b_bit);
    if (a_bit & b_bit)      return KPG_G;
    else if (a_bit | b_bit) return KPG_P;
    else                    return KPG_K;
  endfunction

endpackage

// File: rtl/kpg_prefix.sv
// Recursive-doubling prefix tree: element 0 is the carry-in symbol, element i+1 is bit i.
// Output j is the carry into bit j (j = WIDTH is the carry out).
module kpg_prefix
  import kpg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  kpg_t [WIDTH:0] kpg_i,
  output kpg_t [WIDTH:0] carry_o
);

  localparam int LEVELS = $clog2(WIDTH);

  kpg_t [WIDTH-1:0] cur;
  kpg_t [WIDTH-1:0] nxt;

  // The low WIDTH elements resolve in log2(WIDTH) levels; the top element
  // only needs one more cell against the fully resolved carry into the MSB.
  always_comb begin
    cur = kpg_i[WIDTH-1:0];
    nxt = cur;
    for (int l = 0; l < LEVELS; l++) begin
      nxt = cur;
      for (int j = (1 << l); j < WIDTH; j++) begin
        nxt[j] = kpg_combine(cur[j], cur[j - (1 << l)]);
      end
      cur = nxt;
    end
    carry_o[WIDTH-1:0] = cur;
    carry_o[WIDTH]     = kpg_combine(kpg_i[WIDTH], cur[WIDTH-1]);
  end

endmodule

// File: rtl/kpg_subtractor32.sv
// Three-stage pipelined a - b - bin using the shared KPG prefix carry network.
// All stages advance together whenever the output register is empty or being drained.
module kpg_subtractor32
  import kpg_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  logic adv;

  logic             v1_q;
  logic [WIDTH-1:0] a1_q, bn1_q;
  kpg_t [WIDTH:0]   kpg1_q, kpg1_d;

  kpg_t [WIDTH:0]   carry;

  logic             v2_q;
  logic [WIDTH:0]   carry2_q, carry2_d;
  logic [WIDTH-1:0] x2_q;
  logic             sa2_q, sb2_q;

  logic             v3_q;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

  assign adv      = ~v3_q | out_ready;
  assign in_ready = adv;

  // Borrow-in maps to an inverted carry-in: no borrow means the +1 of two's complement.
  always_comb begin
    kpg1_d[0] = bin ? KPG_K : KPG_G;
    for (int i = 0; i < WIDTH; i++) begin
      kpg1_d[i+1] = kpg_encode(a[i], ~b[i]);
    end
  end

  kpg_prefix #(.WIDTH(WIDTH)) u_prefix (
    .kpg_i   (kpg1_q),
    .carry_o (carry)
  );

  always_comb begin
    for (int i = 0; i <= WIDTH; i++) begin
      carry2_d[i] = (carry[i] == KPG_G);
    end
  end

  always_comb begin
    diff_d = x2_q ^ carry2_q[WIDTH-1:0];
    bout_d = ~carry2_q[WIDTH];
    ovf_d  = (sa2_q != sb2_q) & (diff_d[WIDTH-1] != sa2_q);
    zero_d = ~|diff_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      a1_q     <= '0;
      bn1_q    <= '0;
      for (int i = 0; i <= WIDTH; i++) kpg1_q[i] <= KPG_K;
      v2_q     <= 1'b0;
      carry2_q <= '0;
      x2_q     <= '0;
      sa2_q    <= 1'b0;
      sb2_q    <= 1'b0;
      v3_q     <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else if (adv) begin
      v1_q     <= in_valid;
      a1_q     <= a;
      bn1_q    <= ~b;
      kpg1_q   <= kpg1_d;
      v2_q     <= v1_q;
      carry2_q <= carry2_d;
      x2_q     <= a1_q ^ bn1_q;
      sa2_q    <= a1_q[WIDTH-1];
      sb2_q    <= ~bn1_q[WIDTH-1];
      v3_q     <= v2_q;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign out_valid = v3_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
